// File: rtl/keypad_pkg.sv
// keypad_pkg: shared sizes and helpers for the 4x4 keypad scanner.
package keypad_pkg;

   localparam int KP_ROWS   = 4;
   localparam int KP_COLS   = 4;
   localparam int KP_KEYS   = 16;
   localparam int KP_CODE_W = 4;

   // Index of the lowest set bit of a key mask (0 when the mask is empty).
   function automatic logic [KP_CODE_W-1:0] lsb_index(input logic [KP_KEYS-1:0] mask);
      lsb_index = '0;
      for (int i = KP_KEYS - 1; i >= 0; i--) begin
         if (mask[i]) lsb_index = KP_CODE_W'(i);
      end
   endfunction

endpackage

// File: rtl/keypad_prio_enc.sv
// keypad_prio_enc: combinational lowest-index-first encoder for a key mask.
module keypad_prio_enc
   import keypad_pkg::*;
(
   input  logic [KP_KEYS-1:0]   mask,
   output logic [KP_CODE_W-1:0] idx,
   output logic                 any
);

   assign idx = lsb_index(mask);
   assign any = |mask;

endmodule

// File: rtl/keypad_matrix_scan.sv
// keypad_matrix_scan: 4x4 matrix keypad scanner with frame debounce and a
// valid/ready key event output.
// Optional build macro KEYPAD_RELEASE_EVT_EN adds key release events (key_rel=1).
module keypad_matrix_scan
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV        = 50000,
   parameter int DEBOUNCE_FRAMES = 4
)(
   input  logic                 clk,
   input  logic                 rst_n,
   output logic [KP_ROWS-1:0]   row_n,
   input  logic [KP_COLS-1:0]   col_n,
   output logic                 key_valid,
   input  logic                 key_ready,
   output logic [KP_CODE_W-1:0] key_code,
   output logic                 key_rel,
   output logic                 key_held,
   output logic                 key_ovf
);

   localparam int TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CNT_W  = $clog2(DEBOUNCE_FRAMES + 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_FRAMES);

   logic [KP_COLS-1:0]   col_meta, col_sync;
   logic [TICK_W-1:0]    tick;
   logic [1:0]           r;
   logic                 sample, frame_end;
   logic [KP_KEYS-1:0]   frame, new_frame, cand, stable, stable_d;
   logic [CNT_W-1:0]     cnt;
   logic [KP_KEYS-1:0]   pend, pend_nxt, press_mask, held_press, clr_press, one_code;
   logic [KP_CODE_W-1:0] press_idx;
   logic                 press_any, free, ovf_hit;

`ifdef KEYPAD_RELEASE_EVT_EN
   logic [KP_KEYS-1:0]   rel_pend, rel_pend_nxt, rel_mask, held_rel, clr_rel;
   logic [KP_CODE_W-1:0] rel_idx;
   logic                 rel_any, load_rel, rel_q;

   assign rel_mask = stable_d & ~stable;
   assign key_rel  = rel_q;

   keypad_prio_enc u_rel_enc (.mask(rel_pend), .idx(rel_idx), .any(rel_any));
`else
   assign key_rel = 1'b0;
`endif

   assign sample     = (tick == TICK_LAST);
   assign frame_end  = sample && (r == 2'd3);
   assign row_n      = ~(4'b0001 << r);
   assign press_mask = stable & ~stable_d;

   keypad_prio_enc u_press_enc (.mask(pend), .idx(press_idx), .any(press_any));

   // Two-flop synchronizer for the asynchronous column returns.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_meta <= '0;
         col_sync <= '0;
      end else begin
         col_meta <= col_n;
         col_sync <= col_meta;
      end
   end

   // Row timer: hold each row for SCAN_DIV cycles, advance after the sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick <= '0;
         r    <= '0;
      end else if (sample) begin
         tick <= '0;
         r    <= r + 2'd1;
      end else begin
         tick <= tick + 1'b1;
      end
   end

   // Frame image including the sample being taken this cycle.
   always_comb begin
      new_frame = frame;
      new_frame[{r, 2'b00} +: 4] = ~col_sync;
   end

   // Capture the current row's pressed bits on the last cycle of the row.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) frame <= '0;
      else if (sample) frame <= new_frame;
   end

   // Whole-frame debounce: stable follows cand after enough identical frames.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cand   <= '0;
         cnt    <= '0;
         stable <= '0;
      end else if (frame_end) begin
         if (new_frame != cand) begin
            cand <= new_frame;
            cnt  <= CNT_W'(1);
            if (DEBOUNCE_FRAMES == 1) stable <= new_frame;
         end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
            if (cnt + 1'b1 == CNT_MAX) stable <= cand;
         end
      end
   end

   // Pending-mask update; a press of the key whose event sits unaccepted in
   // the output register is merged into that event (and flagged) rather
   // than queued as a second event.
   always_comb begin
      free       = !key_valid || key_ready;
      one_code   = KP_KEYS'(1) << key_code;
      held_press = (key_valid && !key_ready && !key_rel) ? one_code : '0;
      clr_press  = (free && press_any) ? (KP_KEYS'(1) << press_idx) : '0;
      pend_nxt   = (pend & ~clr_press) | (press_mask & ~held_press);
      ovf_hit    = |(press_mask & ((pend & ~clr_press) | held_press));
`ifdef KEYPAD_RELEASE_EVT_EN
      held_rel     = (key_valid && !key_ready && key_rel) ? one_code : '0;
      load_rel     = free && !press_any && rel_any;
      clr_rel      = load_rel ? (KP_KEYS'(1) << rel_idx) : '0;
      rel_pend_nxt = (rel_pend & ~clr_rel) | (rel_mask & ~held_rel);
      ovf_hit      = ovf_hit | (|(rel_mask & ((rel_pend & ~clr_rel) | held_rel)));
`endif
   end

   // Edge history, pending masks, sticky overflow and held flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stable_d <= '0;
         pend     <= '0;
         key_ovf  <= 1'b0;
         key_held <= 1'b0;
      end else begin
         stable_d <= stable;
         pend     <= pend_nxt;
         key_held <= |stable;
         if (ovf_hit) key_ovf <= 1'b1;
      end
   end

`ifdef KEYPAD_RELEASE_EVT_EN
   // Pending release events.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rel_pend <= '0;
      else        rel_pend <= rel_pend_nxt;
   end
`endif

   // Output register: load the next event whenever the slot is free; presses win.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_valid <= 1'b0;
         key_code  <= '0;
`ifdef KEYPAD_RELEASE_EVT_EN
         rel_q     <= 1'b0;
`endif
      end else if (free) begin
         if (press_any) begin
            key_valid <= 1'b1;
            key_code  <= press_idx;
`ifdef KEYPAD_RELEASE_EVT_EN
            rel_q     <= 1'b0;
         end else if (load_rel) begin
            key_valid <= 1'b1;
            key_code  <= rel_idx;
            rel_q     <= 1'b1;
`endif
         end else begin
            key_valid <= 1'b0;
         end
      end
   end

endmodule
